wdt_cfg_sequencer: RTL and testbench

Bus-master controller that programs and services the watchdog timer over the AXI write channels (AW/W/B). It converts simple start/stop/kick requests into single-beat register writes: WDEN at 0x0100, WDLIVE at 0x0200 and WTOCNT at 0x0300. It also generates periodic WDLIVE kicks autonomously and latches watchdog timeouts as an interrupt. It sits between a CPU-side control register and a master port on the AXI bridge.

---
 rtl/wdt_pkg.sv | 33 +++
 rtl/wdt_kick_timer.sv | 27 ++
 rtl/wdt_cfg_sequencer.sv | 146 ++++++++++++++
 tb/tb_wdt_cfg_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog configuration sequencer: register map,
// write-op encoding and the op -> (offset, data) mapping.
package wdt_pkg;
  localparam logic [15:0] WDT_EN_OFS   = 16'h0100;
  localparam logic [15:0] WDT_LIVE_OFS = 16'h0200;
  localparam logic [15:0] WDT_CNT_OFS  = 16'h0300;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam int         KICK_CNT_W     = 16;

  typedef enum logic [2:0] {OP_CNT, OP_EN, OP_DIS, OP_LIVE1, OP_LIVE0} op_e;
  typedef enum logic [1:0] {IDLE, AW, W, B} state_e;

  typedef struct packed {
    logic [15:0] ofs;
    logic [31:0] data;
  } wr_req_t;

  function automatic wr_req_t op_req(input op_e op, input logic [31:0] tmo);
    wr_req_t r;
    r = '{ofs: WDT_EN_OFS, data: 32'd0};
    case (op)
      OP_CNT:   r = '{ofs: WDT_CNT_OFS, data: tmo};
      OP_EN:    r.data = 32'd1;
      OP_LIVE1: r = '{ofs: WDT_LIVE_OFS, data: 32'd1};
      OP_LIVE0: r.ofs = WDT_LIVE_OFS;
      default:  ;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/wdt_kick_timer.sv
// Free-running kick interval counter with a sticky, coalescing kick request.
module wdt_kick_timer import wdt_pkg::*; #(
  parameter int KICK_PERIOD = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic consume,
  output logic kick_req
);
  logic [KICK_CNT_W-1:0] cnt;
  logic                  wrap;

  assign wrap = run && (cnt == KICK_CNT_W'(KICK_PERIOD - 1));

  // A wrap in the same cycle as consume re-arms the request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      kick_req <= 1'b0;
    end else begin
      if (!run || wrap) cnt <= '0;
      else              cnt <= cnt + 1'b1;
      kick_req <= wrap | (kick_req & ~consume);
    end
  end
endmodule

// File: rtl/wdt_cfg_sequencer.sv
// AXI write master that programs the watchdog (start/stop), issues periodic
// WDLIVE kicks and latches watchdog timeouts and write errors.
module wdt_cfg_sequencer import wdt_pkg::*; #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          KICK_PERIOD = 1024,
  parameter logic [3:0]  MASTER_ID   = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] timeout_val,
  input  logic        kick_en,
  input  logic        wto,
  input  logic        irq_clr,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        busy,
  output logic        active,
  output logic        irq,
  output logic        err
);
  state_e      state;
  op_e         op, ld_op;
  wr_req_t     ld_req;
  logic [31:0] timeout_reg;
  logic        start_pend, stop_pend, wto_q, wto_rise;
  logic        kick_req, take_kick, any_pend, in_idle, has_second;
  logic        unused_bid;

  assign awid    = MASTER_ID;
  assign awlen   = 4'd0;
  assign awsize  = AXI_SIZE_4B;
  assign awburst = AXI_BURST_INCR;
  assign wstrb   = 4'hF;
  assign wlast   = 1'b1;
  assign unused_bid = ^bid;

  assign in_idle    = (state == IDLE);
  assign wto_rise   = wto & ~wto_q;
  assign any_pend   = stop_pend | start_pend | (kick_req & ~irq);
  assign take_kick  = in_idle & ~stop_pend & ~start_pend & kick_req & ~irq;
  assign has_second = (op == OP_CNT) || (op == OP_LIVE1);

  wdt_kick_timer #(.KICK_PERIOD(KICK_PERIOD)) u_kick (
    .clk      (clk),
    .rst      (rst),
    .run      (active & kick_en & ~irq & ~wto_rise),
    .consume  (take_kick | wto_rise),
    .kick_req (kick_req)
  );

  // Next op to load: arbitration winner from IDLE, else the sequence's second op.
  always_comb begin
    if (in_idle) ld_op = stop_pend ? OP_DIS : (start_pend ? OP_CNT : OP_LIVE1);
    else         ld_op = (op == OP_CNT) ? OP_EN : OP_LIVE0;
  end
  assign ld_req = op_req(ld_op, timeout_reg);

  // A stop supersedes any start that has not yet begun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_pend  <= 1'b0;
      stop_pend   <= 1'b0;
      timeout_reg <= '0;
      wto_q       <= 1'b0;
      irq         <= 1'b0;
      err         <= 1'b0;
    end else begin
      stop_pend  <= stop | (stop_pend & ~in_idle);
      start_pend <= ~stop & (start | (start_pend & ~(in_idle & ~stop_pend)));
      if (start) timeout_reg <= timeout_val;
      wto_q <= wto;
      if (wto_rise)     irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
      if (state == B && bvalid && bresp != AXI_RESP_OKAY) err <= 1'b1;
      else if (irq_clr)                                   err <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op      <= OP_CNT;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
      busy    <= 1'b0;
      active  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          busy <= any_pend;
          if (any_pend) begin
            state   <= AW;
            awvalid <= 1'b1;
            op      <= ld_op;
            awaddr  <= BASE_ADDR + {16'h0, ld_req.ofs};
            wdata   <= ld_req.data;
          end
        end
        AW: if (awready) begin
          awvalid <= 1'b0;
          wvalid  <= 1'b1;
          state   <= W;
        end
        W: if (wready) begin
          wvalid <= 1'b0;
          bready <= 1'b1;
          state  <= B;
        end
        B: if (bvalid) begin
          bready <= 1'b0;
          if (op == OP_EN)       active <= 1'b1;
          else if (op == OP_DIS) active <= 1'b0;
          if (has_second) begin
            state   <= AW;
            awvalid <= 1'b1;
            op      <= ld_op;
            awaddr  <= BASE_ADDR + {16'h0, ld_req.ofs};
            wdata   <= ld_req.data;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wdt_cfg_sequencer.sv
// Directed bench: an AXI slave with programmable stalls logs every write, and a
// per-cycle model of irq/err/active plus channel-protocol rules is compared.
module tb_wdt_cfg_sequencer;
  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam int          KP   = 16;

  logic        clk = 0, rst = 1, start = 0, stop = 0, kick_en = 0, wto = 0, irq_clr = 0;
  logic [31:0] timeout_val = 0;
  logic [3:0]  awid, awlen, wstrb;
  logic [31:0] awaddr, wdata;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready = 0, wlast, wvalid, wready = 0, bready;
  logic [3:0]  bid = 4'd2;
  logic [1:0]  bresp = 0;
  logic        bvalid = 0, busy, active, irq, err;

  int errors = 0, checks = 0, cyc = 0;
  int aw_delay = 0, aw_cnt = 0, w_delay = 0, w_cnt = 0;
  bit rand_w = 0, err_inj = 0;
  logic m_irq = 0, m_err = 0, m_active = 0, m_wto_q = 0;
  logic p_awv = 0, p_awf = 0, p_wv = 0, p_wf = 0;
  logic [31:0] p_addr = 0, p_wdata = 0, fl_addr = 0, fl_data = 0;
  logic [63:0] obs[$];
  int          kick_t[$];

  wdt_cfg_sequencer #(.BASE_ADDR(BASE), .KICK_PERIOD(KP), .MASTER_ID(4'd2)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .timeout_val(timeout_val),
    .kick_en(kick_en), .wto(wto), .irq_clr(irq_clr),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .busy(busy), .active(active), .irq(irq), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Runs at each negedge: check outputs, act as slave, advance the model.
  task automatic bus_step();
    logic awf, wf, bf;
    cyc++;
    if (rst) begin
      m_irq = 0; m_err = 0; m_active = 0; m_wto_q = 0;
      awready = 0; wready = 0; bvalid = 0; bresp = 0; aw_cnt = 0; w_cnt = 0;
      p_awv = 0; p_awf = 0; p_wv = 0; p_wf = 0;
      return;
    end
    chk("irq", irq, m_irq);
    chk("err", err, m_err);
    chk("active", active, m_active);
    chk("fixed", {awid, awlen, awsize, awburst, wstrb, wlast},
        {4'd2, 4'd0, 3'b010, 2'b01, 4'hF, 1'b1});
    chk("aw_w_excl", awvalid & wvalid, 0);
    if (p_awv && !p_awf) chk("aw_hold", {awvalid, awaddr}, {1'b1, p_addr});
    if (p_wv && !p_wf)   chk("w_hold", {wvalid, wdata}, {1'b1, p_wdata});

    awready = awvalid && (aw_cnt >= aw_delay);
    if (awvalid && !awready) aw_cnt++;
    awf = awvalid && awready;
    if (awf) begin aw_cnt = 0; fl_addr = awaddr; end
    wready = wvalid && (w_cnt >= w_delay);
    if (wvalid && !wready) w_cnt++;
    wf = wvalid && wready;
    if (wf) begin
      w_cnt = 0;
      fl_data = wdata;
      obs.push_back({fl_addr, wdata});
      if (fl_addr == BASE + 32'h200 && wdata == 32'd1) kick_t.push_back(cyc);
      if (rand_w) w_delay = $urandom_range(0, 3);
    end
    bvalid = bready;
    bresp  = (bready && err_inj) ? 2'b10 : 2'b00;
    bf = bvalid && bready;

    if (bf && bresp != 2'b00) m_err = 1;
    else if (irq_clr)         m_err = 0;
    if (wto && !m_wto_q) m_irq = 1;
    else if (irq_clr)    m_irq = 0;
    m_wto_q = wto;
    if (bf && fl_addr == BASE + 32'h100) m_active = fl_data[0];
    if (bf) err_inj = 0;
    p_awv = awvalid; p_awf = awf; p_addr = awaddr;
    p_wv = wvalid; p_wf = wf; p_wdata = wdata;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      bus_step();
      @(negedge clk);
    end
  endtask

  task automatic exp_wr(input string name, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (obs.size() == 0 && n < 300) begin tick(); n++; end
    if (obs.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: no write seen, want %h/%h", name, a, d);
    end else begin
      chk(name, obs.pop_front(), {a, d});
    end
  endtask

  initial begin
    int n;
    @(negedge clk);
    tick(3);
    chk("rst_outs", {awvalid, wvalid, bready, busy, active, irq, err}, 0);
    chk("rst_addr", {awaddr, wdata}, 0);
    rst = 0;
    tick(3);
    chk("idle_outs", {awvalid, wvalid, bready, busy}, 0);

    // start with zero-wait slave
    timeout_val = 32'h0000_0400; start = 1; tick(); start = 0;
    exp_wr("start_cnt", BASE + 32'h300, 32'h400);
    exp_wr("start_en", BASE + 32'h100, 32'h1);
    n = 0;
    while (!active && n < 50) begin tick(); n++; end
    chk("start_active", active, 1);
    chk("busy_at_active", busy, 1);
    tick();
    chk("busy_after", busy, 0);

    // kicks: none while disabled, then every KP cycles
    tick(40);
    chk("no_kick_disabled", obs.size(), 0);
    kick_en = 1; tick(70); kick_en = 0; tick(20);
    chk("kick_count", obs.size(), 8);
    for (int i = 0; i < 4; i++) begin
      exp_wr("kick_live1", BASE + 32'h200, 32'd1);
      exp_wr("kick_live0", BASE + 32'h200, 32'd0);
    end
    chk("kick_times", kick_t.size(), 4);
    for (int i = 1; i < kick_t.size(); i++) chk("kick_period", kick_t[i] - kick_t[i-1], KP);
    kick_t.delete();

    // stop during the OP_CNT write of a start
    timeout_val = 32'h1234; start = 1; tick(); start = 0;
    n = 0;
    while (!awvalid && n < 50) begin tick(); n++; end
    chk("cnt_aw_seen", {awvalid, awaddr}, {1'b1, BASE + 32'h300});
    stop = 1; tick(); stop = 0;
    exp_wr("stopmid_cnt", BASE + 32'h300, 32'h1234);
    exp_wr("stopmid_en", BASE + 32'h100, 32'd1);
    exp_wr("stopmid_dis", BASE + 32'h100, 32'd0);
    tick(10);
    chk("stopmid_active", active, 0);
    chk("stopmid_busy", busy, 0);

    // start and stop together: only the disable write
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    exp_wr("samecyc_dis", BASE + 32'h100, 32'd0);
    tick(30);
    chk("samecyc_only", obs.size(), 0);
    chk("samecyc_active", active, 0);

    // backpressure: awready late, random wready
    aw_delay = 5; rand_w = 1; w_delay = 2;
    timeout_val = 32'hABCD; start = 1; tick(); start = 0;
    exp_wr("bp_cnt", BASE + 32'h300, 32'hABCD);
    exp_wr("bp_en", BASE + 32'h100, 32'd1);
    tick(10);
    chk("bp_active", active, 1);
    chk("bp_nodup", obs.size(), 0);
    aw_delay = 0; rand_w = 0; w_delay = 0;

    // timeout: irq, kicks stop, error response, clear, kicks resume
    kick_en = 1; tick(20);
    wto = 1; tick(); wto = 0; tick(10);
    chk("wto_irq", irq, 1);
    obs.delete();
    tick(60);
    chk("irq_no_kick", obs.size(), 0);
    err_inj = 1; timeout_val = 32'h55; start = 1; tick(); start = 0;
    exp_wr("irq_cnt", BASE + 32'h300, 32'h55);
    exp_wr("irq_en", BASE + 32'h100, 32'd1);
    tick(5);
    chk("err_set", err, 1);
    chk("irq_held", irq, 1);
    irq_clr = 1; tick(); irq_clr = 0; tick();
    chk("clr_irq_err", {irq, err}, 0);
    exp_wr("resume_live1", BASE + 32'h200, 32'd1);
    exp_wr("resume_live0", BASE + 32'h200, 32'd0);
    kick_en = 0; tick(20);
    obs.delete(); kick_t.delete();

    // asynchronous reset mid-transaction
    start = 1; tick(); start = 0;
    n = 0;
    while (!awvalid && n < 50) begin tick(); n++; end
    rst = 1; #1;
    chk("rst_async", {awvalid, busy, active}, 0);
    tick(3);
    rst = 0; obs.delete();
    tick(20);
    chk("rst_lost", obs.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
